// File: rtl/adc_packet_pkg.sv
// Shared definitions for the ADC packet format: header layout, version and FSM state encoding.
// The packetizer on the transmit side imports the same package.
package adc_packet_pkg;

    localparam int HDR_OFFSET      = 32;
    localparam int HDR_VERSION_LSB = 30;
    localparam int HDR_VERSION_W   = 2;
    localparam int HDR_SOURCE_LSB  = 28;
    localparam int HDR_SOURCE_W    = 2;
    localparam int HDR_CONTROL_BIT = 27;
    localparam int HDR_RSVD_LSB    = 24;
    localparam int HDR_RSVD_W      = 3;
    localparam int HDR_LENGTH_LSB  = 16;
    localparam int HDR_LENGTH_W    = 8;
    localparam int HDR_COUNT_LSB   = 0;
    localparam int HDR_COUNT_W     = 16;

    localparam logic [HDR_VERSION_W-1:0] PACKET_VERSION = 2'd1;

    // Field order mirrors the header bit layout, MSB first.
    typedef struct packed {
        logic [HDR_VERSION_W-1:0] version;
        logic [HDR_SOURCE_W-1:0]  source;
        logic                     control;
        logic [HDR_RSVD_W-1:0]    reserved;
        logic [HDR_LENGTH_W-1:0]  length;
        logic [HDR_COUNT_W-1:0]   count;
    } header_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_CHECK,
        ST_STREAM,
        ST_DONE,
        ST_DROP
    } state_e;

endpackage

// File: rtl/packet_header_parse.sv
// Combinational split of the 32-bit packet header plus the version/length acceptance test.
// Also used by the link-side debug monitor.
module packet_header_parse
    import adc_packet_pkg::*;
#(
    parameter int pPacketSize    = 244,
    parameter int pPacketVersion = 1
) (
    input  logic [HDR_OFFSET-1:0]  iHeader,
    output logic [HDR_SOURCE_W-1:0] oSource,
    output logic                    oControl,
    output logic [HDR_COUNT_W-1:0]  oCount,
    output logic                    oPass
);

    header_t hdr;
    logic    unused_reserved;

    always_comb begin
        hdr      = header_t'(iHeader);
        oSource  = hdr.source;
        oControl = hdr.control;
        oCount   = hdr.count;
        oPass    = (hdr.version == pPacketVersion[HDR_VERSION_W-1:0]) &&
                   (hdr.length == pPacketSize[HDR_LENGTH_W-1:0]);
    end

    // Reserved bits carry no meaning on receive.
    assign unused_reserved = ^hdr.reserved;

endmodule

// File: rtl/packet_to_adc.sv
// Pops one packet from the packet FIFO, validates its header and replays the
// eight-channel sample words one per handshake over a valid/ready stream.
module packet_to_adc
    import adc_packet_pkg::*;
#(
    parameter int pPacketSize       = 244,
    parameter int pPacketVersion    = 1,
    parameter int pSamplesPerPacket = 15,
    parameter int pAdcDataWidth     = 16
) (
    input  logic                       iClk,
    input  logic                       iRst,
    output logic                       oErr,
    input  logic                       iPacketEmpty,
    output logic                       oPacketRd,
    input  logic [pPacketSize*8-1:0]   iPacketData,
    output logic                       oSampleValid,
    input  logic                       iSampleReady,
    output logic [8*pAdcDataWidth-1:0] oAdcSampleData,
    output logic [3:0]                 oSampleIndex,
    output logic [15:0]                oPacketCount,
    output logic [1:0]                 oSource,
    output logic                       oControlBit,
    output logic                       oPacketDone
);

    localparam int         SampleWidth = 8*pAdcDataWidth;
    localparam logic [3:0] LastIndex   = 4'(pSamplesPerPacket-1);

    state_e                   state_q, state_d;
    logic [pPacketSize*8-1:0] pkt_q, pkt_d;
    logic [3:0]               idx_q, idx_d;
    logic [15:0]              count_q, count_d;
    logic [1:0]               source_q, source_d;
    logic                     control_q, control_d;
    logic                     err_q, err_d;
    logic                     rd_q, rd_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic                     hdr_pass;
    logic [1:0]               hdr_source;
    logic                     hdr_control;
    logic [15:0]              hdr_count;
    logic [SampleWidth-1:0]   sample_words [pSamplesPerPacket];

    packet_header_parse #(
        .pPacketSize   (pPacketSize),
        .pPacketVersion(pPacketVersion)
    ) u_header_parse (
        .iHeader (pkt_q[HDR_OFFSET-1:0]),
        .oSource (hdr_source),
        .oControl(hdr_control),
        .oCount  (hdr_count),
        .oPass   (hdr_pass)
    );

    genvar gi;
    generate
        for (gi = 0; gi < pSamplesPerPacket; gi++) begin : g_sample
            assign sample_words[gi] = pkt_q[HDR_OFFSET + gi*SampleWidth +: SampleWidth];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        idx_d     = idx_q;
        count_d   = count_q;
        source_d  = source_q;
        control_d = control_q;
        err_d     = err_q;
        rd_d      = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!iPacketEmpty) begin
                    state_d = ST_READ;
                    rd_d    = 1'b1;
                end
            end
            ST_READ: state_d = ST_LATCH;
            // FIFO data is valid the cycle after the read strobe.
            ST_LATCH: begin
                pkt_d   = iPacketData;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hdr_pass) begin
                    source_d  = hdr_source;
                    control_d = hdr_control;
                    count_d   = hdr_count;
                    idx_d     = 4'd0;
                    valid_d   = 1'b1;
                    state_d   = ST_STREAM;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DROP;
                end
            end
            ST_STREAM: begin
                valid_d = 1'b1;
                if (valid_q && iSampleReady) begin
                    // Index stays on the last sample so it reads back after DONE.
                    if (idx_q == LastIndex) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_DROP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= ST_IDLE;
            pkt_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            source_q  <= '0;
            control_q <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            source_q  <= source_d;
            control_q <= control_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign oErr           = err_q;
    assign oPacketRd      = rd_q;
    assign oSampleValid   = valid_q;
    assign oAdcSampleData = sample_words[idx_q];
    assign oSampleIndex   = idx_q;
    assign oPacketCount   = count_q;
    assign oSource        = source_q;
    assign oControlBit    = control_q;
    assign oPacketDone    = done_q;

endmodule

// File: tb/tb_packet_to_adc.sv
// Scoreboard bench for packet_to_adc: a FIFO model feeds packets, expected samples
// are queued when each packet is built and popped by a monitor on every handshake.
module tb_packet_to_adc;

    localparam int PKT_BYTES = 244;
    localparam int NS        = 15;
    localparam int DW        = 16;
    localparam int SW        = 8*DW;
    localparam int PW        = PKT_BYTES*8;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          oErr;
    logic          iPacketEmpty = 1'b1;
    logic          oPacketRd;
    logic [PW-1:0] iPacketData = '0;
    logic          oSampleValid;
    logic          iSampleReady = 1'b0;
    logic [SW-1:0] oAdcSampleData;
    logic [3:0]    oSampleIndex;
    logic [15:0]   oPacketCount;
    logic [1:0]    oSource;
    logic          oControlBit;
    logic          oPacketDone;

    packet_to_adc #(
        .pPacketSize      (PKT_BYTES),
        .pPacketVersion   (1),
        .pSamplesPerPacket(NS),
        .pAdcDataWidth    (DW)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .oErr          (oErr),
        .iPacketEmpty  (iPacketEmpty),
        .oPacketRd     (oPacketRd),
        .iPacketData   (iPacketData),
        .oSampleValid  (oSampleValid),
        .iSampleReady  (iSampleReady),
        .oAdcSampleData(oAdcSampleData),
        .oSampleIndex  (oSampleIndex),
        .oPacketCount  (oPacketCount),
        .oSource       (oSource),
        .oControlBit   (oControlBit),
        .oPacketDone   (oPacketDone)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [SW-1:0] data;
        logic [3:0]    idx;
        logic [15:0]   count;
        logic [1:0]    source;
        logic          control;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] fifo_q[$];

    int n_checks = 0, n_pass = 0;
    int done_exp = 0, done_seen = 0, rd_seen = 0, pushed = 0;
    int hs_count = 0, valid_cycles = 0;
    bit err_exp = 1'b0;
    int ready_mode = 0;
    int rpat = 0;
    int cyc = 0, last_done_cyc = -1;

    task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: build a packet from its fields and queue what a consumer should see.
    task automatic push_packet(input logic [1:0] ver, input logic [1:0] src, input logic ctl,
                               input logic [2:0] rsvd, input logic [7:0] len,
                               input logic [15:0] cnt, input bit fixed_pattern);
        logic [SW-1:0] s [NS];
        logic [PW-1:0] p;
        bit            good;
        for (int n = 0; n < NS; n++)
            s[n] = fixed_pattern ? {8{16'h0100 + 16'(n)}} : {$urandom, $urandom, $urandom, $urandom};
        p = '0;
        p[31:0] = {ver, src, ctl, rsvd, len, cnt};
        for (int n = 0; n < NS; n++) p[32 + n*SW +: SW] = s[n];
        good = (ver == 2'd1) && (len == 8'(PKT_BYTES));
        if (good) begin
            for (int n = 0; n < NS; n++)
                exp_q.push_back('{data: s[n], idx: 4'(n), count: cnt, source: src, control: ctl});
            done_exp++;
        end else begin
            err_exp = 1'b1;
        end
        fifo_q.push_back(p);
        pushed++;
    endtask

    // FIFO and consumer model: inputs change 2 time units after each rising edge.
    always begin
        @(posedge iClk);
        #2;
        cyc++;
        if (oPacketDone) last_done_cyc = cyc;
        if (oPacketRd) begin
            rd_seen++;
            chk("rd_while_nonempty", iPacketEmpty, 0);
            if (last_done_cyc >= 0) begin
                chk("packet_gap_ge2", (cyc - last_done_cyc) >= 2, 1);
                last_done_cyc = -1;
            end
            chk("rd_fifo_has_data", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) iPacketData = fifo_q.pop_front();
        end
        iPacketEmpty = (fifo_q.size() == 0);
        rpat++;
        case (ready_mode)
            1:       iSampleReady = ((rpat % 3) == 0);
            2:       iSampleReady = 1'($urandom_range(0, 1));
            default: iSampleReady = 1'b1;
        endcase
    end

    exp_t          mon_e;
    bit            stall_pending = 1'b0;
    logic [SW-1:0] held_data;
    logic [3:0]    held_idx;

    always @(negedge iClk) begin
        if (iRst) begin
            if (oPacketDone) done_seen++;
            if (oSampleValid) valid_cycles++;
            if (stall_pending) begin
                chk("hold_valid", oSampleValid, 1);
                chk("hold_data", oAdcSampleData, held_data);
                chk("hold_index", oSampleIndex, held_idx);
            end
            stall_pending = 1'b0;
            if (oSampleValid && iSampleReady) begin
                hs_count++;
                chk("sample_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sample_data", oAdcSampleData, mon_e.data);
                    chk("sample_tag", {oSampleIndex, oPacketCount, oSource, oControlBit},
                        {mon_e.idx, mon_e.count, mon_e.source, mon_e.control});
                    $display("sample idx=%0d count=%h data=%h", oSampleIndex, oPacketCount, oAdcSampleData);
                end
            end else if (oSampleValid) begin
                stall_pending = 1'b1;
                held_data     = oAdcSampleData;
                held_idx      = oSampleIndex;
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    task automatic wait_quiet(input string name);
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || done_seen != done_exp) && t < 3000) begin
            @(negedge iClk);
            t++;
        end
        chk({name, "_completes"}, t < 3000, 1);
        repeat (6) @(negedge iClk);
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    int rd_base, hs_base, vc_base, done_base, edges, t;

    initial begin
        repeat (3) @(negedge iClk);
        chk("reset_outputs", {oErr, oPacketRd, oSampleValid, oPacketDone, oSampleIndex,
                              oPacketCount, oSource, oControlBit}, 0);
        chk("reset_data", oAdcSampleData, 0);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);

        // 1: nominal packet with latency measurement
        rd_base = rd_seen; done_base = done_seen;
        push_packet(2'b01, 2'b10, 1'b1, 3'b000, 8'hF4, 16'h1234, 1'b1);
        @(posedge iClk);
        t = 0;
        while (iPacketEmpty && t < 20) begin @(posedge iClk); t++; end
        edges = 1;
        while (t < 40) begin
            @(negedge iClk);
            if (oSampleValid) break;
            @(posedge iClk);
            edges++;
            t++;
        end
        chk("latency_edges", edges, 4);
        wait_quiet("nominal");
        chk("nominal_rd_once", rd_seen - rd_base, 1);
        chk("nominal_done_once", done_seen - done_base, 1);
        chk("nominal_hold_fields", {oSource, oControlBit, oPacketCount, oSampleIndex, oSampleValid},
            {2'd2, 1'b1, 16'h1234, 4'd14, 1'b0});
        chk("nominal_err", oErr, 0);

        // 2: backpressure 1,0,0 pattern
        ready_mode = 1;
        hs_base = hs_count;
        push_packet(2'b01, 2'b10, 1'b1, 3'b000, 8'hF4, 16'h1234, 1'b1);
        wait_quiet("backpressure");
        chk("backpressure_handshakes", hs_count - hs_base, NS);

        // 3: bad version, then a good packet keeps streaming with sticky error
        ready_mode = 2;
        rd_base = rd_seen; vc_base = valid_cycles;
        push_packet(2'b10, 2'b01, 1'b0, 3'b000, 8'hF4, rnd16(), 1'b0);
        wait_quiet("bad_version");
        chk("bad_version_rd_once", rd_seen - rd_base, 1);
        chk("bad_version_no_valid", valid_cycles - vc_base, 0);
        chk("bad_version_err", oErr, err_exp);
        push_packet(2'b01, 2'b01, 1'b0, 3'b000, 8'hF4, rnd16(), 1'b0);
        wait_quiet("after_bad_version");
        chk("err_sticky", oErr, 1);

        // 4: bad length dropped; reserved bits set still accepted
        vc_base = valid_cycles;
        push_packet(2'b01, 2'b11, 1'b1, 3'b000, 8'hF0, rnd16(), 1'b0);
        wait_quiet("bad_length");
        chk("bad_length_no_valid", valid_cycles - vc_base, 0);
        hs_base = hs_count;
        push_packet(2'b01, 2'b00, 1'b1, 3'b111, 8'hF4, rnd16(), 1'b0);
        wait_quiet("reserved_ignored");
        chk("reserved_ignored_handshakes", hs_count - hs_base, NS);

        // 5: three packets back to back, full-rate consumer
        ready_mode = 0;
        done_base = done_seen; hs_base = hs_count;
        push_packet(2'b01, 2'b01, 1'b0, 3'b000, 8'hF4, 16'hAAAA, 1'b0);
        push_packet(2'b01, 2'b10, 1'b1, 3'b000, 8'hF4, 16'hAAAB, 1'b0);
        push_packet(2'b01, 2'b11, 1'b0, 3'b000, 8'hF4, 16'hAAAC, 1'b0);
        wait_quiet("back_to_back");
        chk("b2b_done_pulses", done_seen - done_base, 3);
        chk("b2b_samples", hs_count - hs_base, 3*NS);
        chk("b2b_last_count", oPacketCount, 16'hAAAC);

        // 6: asynchronous reset at index 7
        push_packet(2'b01, 2'b10, 1'b0, 3'b000, 8'hF4, rnd16(), 1'b0);
        t = 0;
        while (!(oSampleValid && oSampleIndex == 4'd7) && t < 200) begin @(negedge iClk); t++; end
        chk("reach_index7", t < 200, 1);
        #2 iRst = 1'b0;
        #1;
        chk("async_reset_outputs", {oErr, oPacketRd, oSampleValid, oPacketDone, oSampleIndex,
                                    oPacketCount, oSource, oControlBit}, 0);
        chk("async_reset_data", oAdcSampleData, 0);
        exp_q.delete();
        done_exp = done_seen;
        err_exp = 1'b0;
        last_done_cyc = -1;
        @(negedge iClk);
        #3 iRst = 1'b1;
        push_packet(2'b01, 2'b01, 1'b1, 3'b000, 8'hF4, rnd16(), 1'b0);
        wait_quiet("after_reset");
        chk("after_reset_err", oErr, 0);

        // 7: random mix of good and bad headers with random ready
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            push_packet(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01, 2'($urandom), 1'($urandom),
                        3'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hF4, rnd16(), 1'b0);
            repeat ($urandom_range(0, 30)) @(negedge iClk);
        end
        wait_quiet("random_mix");
        chk("random_err", oErr, err_exp);
        chk("random_done_count", done_seen, done_exp);
        chk("total_reads", rd_seen, pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
